// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment codes, controller
// states and the power-of-ten helper used to size the overflow limit.
package seg_pkg;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } drv_state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned k = 0; k < n; k++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Non-decimal nibbles only appear on overflow, which is displayed as dashes.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] code;
        code = SEG_BLANK;
        if (d < 4'd10) begin
            code = SEG_DIGIT[d];
        end
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Value/valid/ready input bundle of the scan driver.
interface seg_scan_driver_if #(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
);
    localparam int DP_W = $clog2(DIGITS + 1);

    logic [VAL_W-1:0] in_value;
    logic             in_valid;
    logic             in_ready;
    logic             blank_lz;
    logic [DP_W-1:0]  dp_pos;

    modport master (
        output in_value,
        output in_valid,
        output blank_lz,
        output dp_pos,
        input  in_ready
    );

    modport slave (
        input  in_value,
        input  in_valid,
        input  blank_lz,
        input  dp_pos,
        output in_ready
    );
endinterface

// File: rtl/seg_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// done pulses for one cycle after the last shift; bcd holds the result until the next start.
module seg_bin2bcd #(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  inclk0,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      value,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                bin_reg  <= value;
                bcd_reg  <= '0;
                cnt_reg  <= CNT_W'(VAL_W);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                // Excess BCD digits beyond DIGITS fall off the top; the caller flags that as overflow.
                {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
                cnt_reg            <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: accepts a binary value, converts it to BCD,
// commits a display shadow atomically and scans digits at a fixed prescaled rate.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic              inclk0,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus,
    output logic [DIGITS-1:0] sel,
    output logic [6:0]        codeout,
    output logic              dp,
    output logic              ovf
);
    localparam int DP_W  = $clog2(DIGITS + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [31:0] OVF_LIMIT = 32'(pow10(DIGITS) - 1);

    drv_state_t state_reg;
    drv_state_t state_next;
    logic       start;
    logic       commit;
    logic       conv_done;
    logic [4*DIGITS-1:0] bcd;

    logic            blank_reg;
    logic [DP_W-1:0] dp_eff_reg;
    logic            ovf_pend_reg;

    logic [DIGITS:0]   zero_from;
    logic [6:0]        code_new [DIGITS];
    logic [DIGITS-1:0] dp_new;

    logic [6:0]        shadow_code_reg [DIGITS];
    logic [DIGITS-1:0] shadow_dp_reg;
    logic              ovf_reg;

    logic [PRE_W-1:0]  presc_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              step;
    logic [DIGITS-1:0] sel_reg;
    logic [6:0]        code_reg;
    logic              dp_reg;

    // ---------------- accept / convert / commit controller ----------------
    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    start      = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (conv_done) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.in_ready = (state_reg == ST_IDLE);

    // Display attributes travel with the value so a later input cannot disturb a conversion.
    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            blank_reg    <= 1'b0;
            dp_eff_reg   <= '0;
            ovf_pend_reg <= 1'b0;
        end else if (start) begin
            blank_reg    <= bus.blank_lz;
            dp_eff_reg   <= (32'(bus.dp_pos) > 32'(DIGITS)) ? '0 : bus.dp_pos;
            ovf_pend_reg <= (32'(bus.in_value) > OVF_LIMIT);
        end
    end

    seg_bin2bcd #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .inclk0 (inclk0),
        .rst_n  (rst_n),
        .start  (start),
        .value  (bus.in_value),
        .done   (conv_done),
        .bcd    (bcd)
    );

    // ---------------- per-digit code generation for the next shadow ----------------
    assign zero_from[DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic       lead_blank;

            assign nib           = bcd[4*gi +: 4];
            assign zero_from[gi] = zero_from[gi+1] && (nib == 4'd0);
            // Digit 0 and every digit carrying or right of the point always show a numeral.
            assign lead_blank    = blank_reg && (gi != 0)
                                && (dp_eff_reg <= DP_W'(gi)) && zero_from[gi];
            assign code_new[gi]  = ovf_pend_reg ? SEG_DASH
                                 : lead_blank   ? SEG_BLANK
                                 : seg_encode(nib);
            assign dp_new[gi]    = !ovf_pend_reg && (dp_eff_reg == DP_W'(gi + 1));
        end
    endgenerate

    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow_code_reg[i] <= SEG_BLANK;
            end
            shadow_dp_reg <= '0;
            ovf_reg       <= 1'b0;
        end else if (commit) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow_code_reg[i] <= code_new[i];
            end
            shadow_dp_reg <= dp_new;
            ovf_reg       <= ovf_pend_reg;
        end
    end

    // ---------------- digit scan ----------------
    assign step = (presc_reg == PRE_W'(SCAN_DIV - 1));

    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (step) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
        end
    end

    // Outputs sample the shadow only at a step, so a commit never splits a digit.
    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            sel_reg  <= '0;
            code_reg <= SEG_BLANK;
            dp_reg   <= 1'b0;
        end else if (step) begin
            idx_reg  <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
            sel_reg  <= DIGITS'(1) << idx_reg;
            code_reg <= shadow_code_reg[idx_reg];
            dp_reg   <= shadow_dp_reg[idx_reg];
        end
    end

    assign sel     = sel_reg;
    assign codeout = code_reg;
    assign dp      = dp_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, VAL_W=14, SCAN_DIV=4) with
// directed scenarios and randomized values checked against an arithmetic display model.
module tb_seg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int VAL_W    = 14;
    localparam int SCAN_DIV = 4;
    localparam int LIMIT    = 9999;
    localparam int LAT_LOW  = VAL_W + 1;

    logic              inclk0 = 1'b0;
    logic              rst_n  = 1'b0;
    logic [DIGITS-1:0] sel;
    logic [6:0]        codeout;
    logic              dp;
    logic              ovf;

    int errors = 0;
    int checks = 0;

    logic [6:0] obs_code [DIGITS];
    logic       obs_dp   [DIGITS];
    logic       obs_ok;
    logic [6:0] seg_tab  [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg_scan_driver_if #(.VAL_W(VAL_W), .DIGITS(DIGITS)) bus ();

    seg_scan_driver #(
        .DIGITS   (DIGITS),
        .VAL_W    (VAL_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .inclk0  (inclk0),
        .rst_n   (rst_n),
        .bus     (bus),
        .sel     (sel),
        .codeout (codeout),
        .dp      (dp),
        .ovf     (ovf)
    );

    always #5 inclk0 = ~inclk0;

    // Reference: decimal digit d of v from plain division, then the display rules.
    function automatic logic [6:0] model_code(input int v, input bit blz, input int dpp, input int d);
        int pw;
        int dpe;
        pw = 1;
        for (int k = 0; k < d; k++) pw = pw * 10;
        dpe = (dpp > DIGITS) ? 0 : dpp;
        if (v > LIMIT) return 7'h40;
        if (blz && d != 0 && d >= dpe && (v / pw) == 0) return 7'h00;
        return seg_tab[(v / pw) % 10];
    endfunction

    function automatic logic model_dp(input int v, input int dpp, input int d);
        int dpe;
        dpe = (dpp > DIGITS) ? 0 : dpp;
        return (v <= LIMIT) && (dpe != 0) && (d == dpe - 1);
    endfunction

    // Present a value, wait for accept, then count cycles with in_ready low.
    task automatic send(input int v, input bit blz, input int dpp, output int low);
        int n;
        @(negedge inclk0);
        bus.in_value = VAL_W'(v);
        bus.blank_lz = blz;
        bus.dp_pos   = 3'(dpp);
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge inclk0);
            n++;
        end
        @(negedge inclk0);
        bus.in_valid = 1'b0;
        low = 0;
        while (bus.in_ready !== 1'b1 && low < 100) begin
            low++;
            @(negedge inclk0);
        end
        $display("txn value=%0d blank_lz=%0d dp_pos=%0d ready_low=%0d", v, blz, dpp, low);
    endtask

    // Wait until a digit step after the commit, then record one frame of the scan.
    task automatic collect();
        int n;
        obs_ok = 1'b1;
        repeat (SCAN_DIV + 1) @(negedge inclk0);
        for (int d = 0; d < DIGITS; d++) begin
            n = 0;
            while (sel !== DIGITS'(1 << d) && n < 4 * SCAN_DIV * DIGITS) begin
                @(negedge inclk0);
                n++;
            end
            if (sel !== DIGITS'(1 << d)) obs_ok = 1'b0;
            obs_code[d] = codeout;
            obs_dp[d]   = dp;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.blank_lz = 1'b0;
        bus.dp_pos   = '0;
        #12;
        checks++;
        if (sel !== 4'h0 || codeout !== 7'h00 || dp !== 1'b0 || ovf !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: got sel=%h code=%h dp=%b ovf=%b, expected all zero", sel, codeout, dp, ovf); end
        checks++;
        if (bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
        @(negedge inclk0);
        rst_n = 1'b1;
        repeat (SCAN_DIV - 1) @(negedge inclk0);
        checks++;
        if (sel !== 4'h0)
            begin errors++; $display("FAIL reset_no_early_sel: got %h expected 0", sel); end
    endtask

    task automatic test_basic();
        int low;
        logic [6:0] exp_c [DIGITS];
        exp_c = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        send(1234, 1'b0, 0, low);
        checks++;
        if (low != LAT_LOW) begin errors++; $display("FAIL basic_ready_low: got %0d expected %0d", low, LAT_LOW); end
        collect();
        checks++;
        if (!obs_ok) begin errors++; $display("FAIL basic_scan: sel sequence not seen, got %b expected 1", obs_ok); end
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== exp_c[d] || obs_dp[d] !== 1'b0)
                begin errors++; $display("FAIL basic_digit%0d: got %h/%b expected %h/0", d, obs_code[d], obs_dp[d], exp_c[d]); end
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_blanking();
        int low;
        send(7, 1'b1, 0, low);
        collect();
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== ((d == 0) ? 7'h07 : 7'h00))
                begin errors++; $display("FAIL blank7_digit%0d: got %h expected %h", d, obs_code[d], (d == 0) ? 7'h07 : 7'h00); end
        end
        send(0, 1'b1, 0, low);
        collect();
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== ((d == 0) ? 7'h3F : 7'h00))
                begin errors++; $display("FAIL blank0_digit%0d: got %h expected %h", d, obs_code[d], (d == 0) ? 7'h3F : 7'h00); end
        end
    endtask

    task automatic test_overflow();
        int low;
        send(10000, 1'b1, 2, low);
        collect();
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== 7'h40 || obs_dp[d] !== 1'b0)
                begin errors++; $display("FAIL ovf_digit%0d: got %h/%b expected 40/0", d, obs_code[d], obs_dp[d]); end
        end
        send(9999, 1'b0, 0, low);
        collect();
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== 7'h6F)
                begin errors++; $display("FAIL max_digit%0d: got %h expected 6F", d, obs_code[d]); end
        end
    endtask

    task automatic test_dp();
        int low;
        logic [6:0] exp_c [DIGITS];
        logic [3:0] exp_d;
        exp_c = '{7'h6D, 7'h3F, 7'h00, 7'h00};
        exp_d = 4'b0010;
        send(5, 1'b1, 2, low);
        collect();
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== exp_c[d] || obs_dp[d] !== exp_d[d])
                begin errors++; $display("FAIL dp_digit%0d: got %h/%b expected %h/%b", d, obs_code[d], obs_dp[d], exp_c[d], exp_d[d]); end
        end
    endtask

    task automatic test_abort_reset();
        @(negedge inclk0);
        bus.in_value = VAL_W'(4321);
        bus.blank_lz = 1'b0;
        bus.dp_pos   = '0;
        bus.in_valid = 1'b1;
        @(negedge inclk0);
        bus.in_valid = 1'b0;
        $display("txn value=4321 accepted, reset mid-conversion");
        repeat (4) @(negedge inclk0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 4'h0 || codeout !== 7'h00 || dp !== 1'b0 || ovf !== 1'b0)
            begin errors++; $display("FAIL abort_outputs: got sel=%h code=%h dp=%b ovf=%b, expected all zero", sel, codeout, dp, ovf); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.in_ready); end
        repeat (2) @(negedge inclk0);
        rst_n = 1'b1;
        for (int k = 1; k <= SCAN_DIV; k++) begin
            @(negedge inclk0);
            checks++;
            if (sel !== ((k == SCAN_DIV) ? 4'b0001 : 4'b0000))
                begin errors++; $display("FAIL abort_first_wrap_k%0d: got sel=%b expected %b", k, sel, (k == SCAN_DIV) ? 4'b0001 : 4'b0000); end
        end
        checks++;
        if (codeout !== 7'h00) begin errors++; $display("FAIL abort_first_code: got %h expected 00", codeout); end
        repeat (VAL_W + 6) @(negedge inclk0);
        collect();
        checks++;
        if (ovf !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL abort_no_commit_state: got ovf=%b ready=%b expected 0/1", ovf, bus.in_ready); end
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== 7'h00 || obs_dp[d] !== 1'b0)
                begin errors++; $display("FAIL abort_digit%0d: got %h/%b expected 00/0", d, obs_code[d], obs_dp[d]); end
        end
    endtask

    task automatic test_back_to_back();
        int low;
        int n;
        @(negedge inclk0);
        bus.in_value = VAL_W'(1111);
        bus.blank_lz = 1'b0;
        bus.dp_pos   = '0;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge inclk0); n++; end
        @(negedge inclk0);
        bus.in_value = VAL_W'(2222);
        $display("txn value=1111 accepted, 2222 held valid while busy");
        low = 0;
        while (bus.in_ready !== 1'b1 && low < 100) begin low++; @(negedge inclk0); end
        checks++;
        if (low != LAT_LOW) begin errors++; $display("FAIL b2b_ready_low: got %0d expected %0d", low, LAT_LOW); end
        @(negedge inclk0);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready=%b expected 0", bus.in_ready); end
        repeat (4) @(negedge inclk0);
        checks++;
        if (codeout !== 7'h06) begin errors++; $display("FAIL b2b_first_value: got %h expected 06", codeout); end
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge inclk0); n++; end
        $display("txn value=2222 accepted after ready returned");
        collect();
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (obs_code[d] !== 7'h5B)
                begin errors++; $display("FAIL b2b_digit%0d: got %h expected 5B", d, obs_code[d]); end
        end
    endtask

    task automatic test_random();
        int v;
        int kind;
        int dpp;
        int low;
        bit blz;
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0)      v = int'($urandom_range(0, 99));
            else if (kind == 1) v = int'($urandom_range(10000, 16383));
            else                v = int'($urandom_range(0, 9999));
            blz = 1'($urandom_range(0, 1));
            dpp = int'($urandom_range(0, 7));
            send(v, blz, dpp, low);
            checks++;
            if (low != LAT_LOW) begin errors++; $display("FAIL rand%0d_ready_low: got %0d expected %0d", it, low, LAT_LOW); end
            collect();
            checks++;
            if (!obs_ok) begin errors++; $display("FAIL rand%0d_scan: got %b expected 1", it, obs_ok); end
            checks++;
            if (ovf !== (v > LIMIT)) begin errors++; $display("FAIL rand%0d_ovf: got %b expected %b", it, ovf, v > LIMIT); end
            for (int d = 0; d < DIGITS; d++) begin
                checks++;
                if (obs_code[d] !== model_code(v, blz, dpp, d) || obs_dp[d] !== model_dp(v, dpp, d))
                    begin errors++; $display("FAIL rand%0d_digit%0d v=%0d: got %h/%b expected %h/%b", it, d, v, obs_code[d], obs_dp[d], model_code(v, blz, dpp, d), model_dp(v, dpp, d)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_dp();
        test_abort_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
